ncl_rail_arbiter: RTL and testbench

NCL_RAIL_ARBITER -- requirements
Module: ncl_rail_arbiter

---
 rtl/ncl_rail_arbiter.sv | 122 ++++++++++++
 tb/tb_ncl_rail_arbiter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ncl_rail_arbiter.sv
// Two-requester round-robin injector onto a 1-of-4 NCL rail with DATA/NULL handshake and watchdog.
// Define NCL_ACK_SYNC_EN to pass rail_ack through a two-flop synchronizer before use.
module ncl_rail_arbiter #(
    parameter int unsigned WATCHDOG = 255
) (
    input  logic       clk,
    input  logic       init_n,
    input  logic       req0_valid,
    input  logic [1:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [1:0] req1_data,
    output logic       req1_ready,
    output logic [3:0] rail,
    input  logic       rail_ack,
    output logic       grant,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic [1:0] {StIdle, StWaitD, StWaitN} state_e;

    localparam int unsigned CntW = $clog2(WATCHDOG + 2);
    localparam logic [CntW-1:0] WdLimit = CntW'(WATCHDOG);

    state_e          state_q, state_d;
    logic [3:0]      rail_q, rail_d;
    logic            grant_q, grant_d;
    logic            timeout_q, timeout_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ack_s;
    logic            can_xfer;
    logic            pick1;
    logic            xfer;
    logic [1:0]      sel_data;

`ifdef NCL_ACK_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!init_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], rail_ack};
        end
    end

    assign ack_s = sync_q[1];
`else
    assign ack_s = rail_ack;
`endif

    // Requester 1 wins when it is the only one valid, or when both are valid and 0 went last.
    assign can_xfer   = init_n && (state_q == StIdle) && !ack_s && !timeout_q;
    assign pick1      = req1_valid && (!req0_valid || !grant_q);
    assign req0_ready = can_xfer && req0_valid && !pick1;
    assign req1_ready = can_xfer && pick1;
    assign xfer       = req0_ready || req1_ready;
    assign sel_data   = pick1 ? req1_data : req0_data;

    always_comb begin
        state_d   = state_q;
        rail_d    = rail_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (!timeout_q) begin
            unique case (state_q)
                StIdle: begin
                    if (xfer) begin
                        state_d = StWaitD;
                        rail_d  = 4'b0001 << sel_data;
                        grant_d = pick1;
                    end
                end
                StWaitD: begin
                    if (ack_s) begin
                        state_d = StWaitN;
                        rail_d  = 4'b0000;
                    end
                end
                StWaitN: begin
                    if (!ack_s) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
            // Phase counter restarts on every state change; only handshake phases are timed.
            if (state_d != state_q) begin
                cnt_d = '0;
            end else if (state_q != StIdle) begin
                cnt_d = cnt_q + CntW'(1);
                if ((WATCHDOG != 0) && (cnt_d == WdLimit)) begin
                    timeout_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!init_n) begin
            state_q   <= StIdle;
            rail_q    <= 4'b0000;
            grant_q   <= 1'b1;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rail_q    <= rail_d;
            grant_q   <= grant_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign rail        = rail_q;
    assign grant       = grant_q;
    assign busy        = (state_q != StIdle);
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_ncl_rail_arbiter.sv
// Self-checking bench for ncl_rail_arbiter: directed scenarios plus a randomized round-robin run.
module tb_ncl_rail_arbiter;

`ifdef NCL_ACK_SYNC_EN
    localparam int AckLag = 2;
`else
    localparam int AckLag = 0;
`endif

    logic       clk = 1'b0;
    logic       init_n;
    logic       req0_valid, req1_valid;
    logic [1:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic [3:0] rail;
    logic       rail_ack;
    logic       grant, busy, timeout_err;

    int   checks = 0;
    int   errors = 0;
    logic auto_ack = 1'b0;
    logic [3:0] pipe = 4'b0000;

    always #5 clk = ~clk;

    ncl_rail_arbiter #(.WATCHDOG(16)) dut (
        .clk        (clk),
        .init_n     (init_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rail       (rail),
        .rail_ack   (rail_ack),
        .grant      (grant),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    // One clock; a 4-stage pipeline loops rail occupancy back as rail_ack when enabled.
    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_ack) begin
            pipe     = {pipe[2:0], |rail};
            rail_ack = pipe[3];
        end
        #1;
    endtask

    task automatic do_reset();
        init_n     = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = 2'd0;
        req1_data  = 2'd0;
        rail_ack   = 1'b0;
        pipe       = 4'b0000;
        tick();
        tick();
        init_n = 1'b1;
        #1;
    endtask

    task automatic settle(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!busy && !rail_ack && rail == 4'b0000) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        init_n = 1'b0;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
        end
        tick();
        checks++;
        if (rail !== 4'b0000 || busy !== 1'b0 || grant !== 1'b1 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rail=%b busy=%b grant=%b to=%b want 0000 0 1 0",
                     rail, busy, grant, timeout_err);
        end
        do_reset();
    endtask

    task automatic test_single();
        int   ready_cycles;
        logic ok;
        do_reset();
        auto_ack   = 1'b1;
        req0_valid = 1'b1;
        req0_data  = 2'd2;
        #1;
        ready_cycles = req0_ready ? 1 : 0;
        tick();
        req0_valid = 1'b0;
        checks++;
        if (rail !== 4'b0100 || grant !== 1'b0) begin
            errors++;
            $display("FAIL single_data: rail=%b grant=%b want 0100 0", rail, grant);
        end
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (req0_ready) ready_cycles++;
            if (rail == 4'b0000) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_null: rail=%b busy=%b want 0000 1", rail, busy);
        end
        settle(ok);
        checks++;
        if (!ok || ready_cycles != 1) begin
            errors++;
            $display("FAIL single_idle: idle=%b ready_cycles=%0d want 1 1", ok, ready_cycles);
        end
        auto_ack = 1'b0;
    endtask

    task automatic test_contention();
        int   n;
        int   w;
        do_reset();
        auto_ack   = 1'b1;
        req0_valid = 1'b1;
        req0_data  = 2'd1;
        req1_valid = 1'b1;
        req1_data  = 2'd3;
        n = 0;
        for (int c = 0; c < 400 && n < 8; c++) begin
            #1;
            if (req0_ready || req1_ready) begin
                w = req1_ready ? 1 : 0;
                checks++;
                if ((req0_ready && req1_ready) || w != n % 2) begin
                    errors++;
                    $display("FAIL contention_winner%0d: ready=%b%b want winner %0d",
                             n, req1_ready, req0_ready, n % 2);
                end
                tick();
                checks++;
                if (rail !== (w == 1 ? 4'b1000 : 4'b0010) || grant !== w[0]) begin
                    errors++;
                    $display("FAIL contention_rail%0d: rail=%b grant=%b want %b %0d",
                             n, rail, grant, (w == 1 ? 4'b1000 : 4'b0010), w);
                end
                n++;
            end else begin
                tick();
            end
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL contention_count: got %0d want 8", n);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        auto_ack   = 1'b0;
        do_reset();
    endtask

    task automatic test_latency();
        int   n;
        do_reset();
        req1_valid = 1'b1;
        req1_data  = 2'd1;
        tick();
        req1_valid = 1'b0;
        checks++;
        if (rail !== 4'b0010) begin
            errors++;
            $display("FAIL latency_data: rail=%b want 0010 one cycle after valid", rail);
        end
        tick();
        rail_ack = 1'b1;
        n = 0;
        for (int i = 0; i < 10 && rail != 4'b0000; i++) begin
            tick();
            n++;
        end
        checks++;
        if (n != 1 + AckLag) begin
            errors++;
            $display("FAIL latency_null: edges=%0d want %0d", n, 1 + AckLag);
        end
        rail_ack = 1'b0;
        n = 0;
        for (int i = 0; i < 10 && busy; i++) begin
            tick();
            n++;
        end
        checks++;
        if (n != 1 + AckLag) begin
            errors++;
            $display("FAIL latency_idle: edges=%0d want %0d", n, 1 + AckLag);
        end
    endtask

    task automatic test_undrained();
        logic seen;
        do_reset();
        rail_ack = 1'b1;
        for (int i = 0; i <= AckLag; i++) tick();
        req1_valid = 1'b1;
        req1_data  = 2'd3;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (req1_ready || req0_ready) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen || busy !== 1'b0) begin
            errors++;
            $display("FAIL undrained_hold: ready_seen=%b busy=%b want 0 0", seen, busy);
        end
        rail_ack = 1'b0;
        for (int i = 0; i < AckLag; i++) tick();
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL undrained_release: req1_ready=%b want 1", req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        checks++;
        if (rail !== 4'b1000 || grant !== 1'b1) begin
            errors++;
            $display("FAIL undrained_xfer: rail=%b grant=%b want 1000 1", rail, grant);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req1_valid = 1'b1;
        req1_data  = 2'd2;
        tick();
        req1_valid = 1'b0;
        tick();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        init_n     = 1'b0;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL resetmid_pre: ready=%b%b busy=%b want 00 1", req1_ready, req0_ready, busy);
        end
        tick();
        init_n = 1'b1;
        checks++;
        if (rail !== 4'b0000 || busy !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL resetmid_state: rail=%b busy=%b to=%b want 0000 0 0",
                     rail, busy, timeout_err);
        end
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL resetmid_rr: ready=%b%b want 01", req1_ready, req0_ready);
        end
        do_reset();
    endtask

    task automatic test_watchdog();
        do_reset();
        req0_valid = 1'b1;
        req0_data  = 2'd0;
        tick();
        req0_valid = 1'b0;
        checks++;
        if (rail !== 4'b0001) begin
            errors++;
            $display("FAIL wd_data: rail=%b want 0001", rail);
        end
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 15) begin
                checks++;
                if (timeout_err !== 1'b0) begin
                    errors++;
                    $display("FAIL wd_early: timeout_err=%b at 15 want 0", timeout_err);
                end
            end
        end
        checks++;
        if (timeout_err !== 1'b1 || rail !== 4'b0001) begin
            errors++;
            $display("FAIL wd_fire: timeout_err=%b rail=%b want 1 0001", timeout_err, rail);
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rail_ack   = 1'b1;
        for (int i = 0; i < AckLag + 3; i++) tick();
        checks++;
        if (req0_ready || req1_ready || rail !== 4'b0001 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL wd_freeze: ready=%b%b rail=%b to=%b want 00 0001 1",
                     req1_ready, req0_ready, rail, timeout_err);
        end
        do_reset();
    endtask

    // Reference: transfer only where drained; winner is the sole valid, else the one not granted last.
    task automatic test_random();
        int         last_g;
        int         exp_w;
        int         w;
        int         xfers;
        logic [1:0] d;
        logic       ok;
        do_reset();
        auto_ack = 1'b1;
        last_g   = 1;
        xfers    = 0;
        for (int c = 0; c < 400; c++) begin
            if (!req0_valid) begin
                if ($urandom_range(1, 0) == 1) begin
                    req0_valid = 1'b1;
                    req0_data  = 2'($urandom_range(3, 0));
                end
            end else if ($urandom_range(7, 0) == 0) begin
                req0_valid = 1'b0;
            end
            if (!req1_valid) begin
                if ($urandom_range(1, 0) == 1) begin
                    req1_valid = 1'b1;
                    req1_data  = 2'($urandom_range(3, 0));
                end
            end else if ($urandom_range(7, 0) == 0) begin
                req1_valid = 1'b0;
            end
            #1;
            if (req0_ready || req1_ready) begin
                exp_w = (req0_valid && req1_valid) ? (last_g == 0 ? 1 : 0) : (req1_valid ? 1 : 0);
                w     = req1_ready ? 1 : 0;
                d     = (w == 1) ? req1_data : req0_data;
                checks++;
                if ((req0_ready && req1_ready) || w != exp_w || busy || rail != 4'b0000) begin
                    errors++;
                    $display("FAIL rand_grant c%0d: ready=%b%b busy=%b rail=%b want winner %0d",
                             c, req1_ready, req0_ready, busy, rail, exp_w);
                end
                tick();
                checks++;
                if (rail !== (4'b0001 << d) || grant !== exp_w[0]) begin
                    errors++;
                    $display("FAIL rand_rail c%0d: rail=%b grant=%b want %b %0d",
                             c, rail, grant, 4'b0001 << d, exp_w);
                end
                last_g = exp_w;
                if (w == 1) req1_valid = 1'b0;
                else        req0_valid = 1'b0;
                xfers++;
            end else begin
                tick();
            end
            if ($countones(rail) > 1) begin
                checks++;
                errors++;
                $display("FAIL rand_onehot c%0d: rail=%b", c, rail);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        settle(ok);
        checks++;
        if (xfers < 10 || !ok) begin
            errors++;
            $display("FAIL rand_progress: xfers=%0d idle=%b want >=10 1", xfers, ok);
        end
        auto_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_latency();
        test_undrained();
        test_reset_mid();
        test_watchdog();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
